// File: rtl/ltp_pkg.sv
// ltp_pkg: shared encodings and edge-qualify helper for level_to_pulse_array
package ltp_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   function automatic logic qualify(input logic [1:0] m, input logic rise, input logic fall);
      return (rise & m[0]) | (fall & m[1]);
   endfunction

endpackage

// File: rtl/ltp_channel.sv
// ltp_channel: one edge-to-pulse channel; LTP_SYNC_EN adds a two-flop input synchroniser
module ltp_channel
   import ltp_pkg::*;
#(
   parameter int PULSE_LEN = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       level,
   input  logic [1:0] mode,
   output logic       pulse
);

   localparam logic [7:0] RELOAD = 8'(PULSE_LEN - 1);

   logic       lvl;
   logic       level_q;
   logic       trig;
   logic [7:0] cnt;
   state_t     state;

`ifdef LTP_SYNC_EN
   logic [1:0] sync;

   // two-flop synchroniser for an asynchronous level
   always_ff @(posedge clk or negedge reset)
      if (!reset) sync <= 2'b00;
      else        sync <= {sync[0], level};

   assign lvl = sync[1];
`else
   assign lvl = level;
`endif

   assign trig = qualify(mode, lvl & ~level_q, ~lvl & level_q);

   // edge history plus IDLE/ACTIVE pulse timer; pulse is a flop tracking ACTIVE
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         level_q <= 1'b0;
         state   <= IDLE;
         cnt     <= 8'd0;
         pulse   <= 1'b0;
      end else begin
         level_q <= lvl;
         case (state)
            IDLE:
               if (trig) begin
                  state <= ACTIVE;
                  cnt   <= RELOAD;
                  pulse <= 1'b1;
               end
            ACTIVE:
               if (trig) cnt <= RELOAD;
               else if (cnt == 8'd0) begin
                  state <= IDLE;
                  pulse <= 1'b0;
               end else cnt <= cnt - 8'd1;
            default: begin
               state <= IDLE;
               pulse <= 1'b0;
            end
         endcase
      end

endmodule

// File: rtl/level_to_pulse_array.sv
// level_to_pulse_array: N independent level-edge to fixed-width pulse channels (option LTP_SYNC_EN)
module level_to_pulse_array
   import ltp_pkg::*;
#(
   parameter int N         = 4,
   parameter int PULSE_LEN = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   level,
   input  logic [2*N-1:0] mode,
   output logic [N-1:0]   pulse,
   output logic           any_pulse
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      ltp_channel #(.PULSE_LEN(PULSE_LEN)) u_ch (
         .clk   (clk),
         .reset (reset),
         .level (level[i]),
         .mode  (mode[2*i +: 2]),
         .pulse (pulse[i])
      );
   end

   assign any_pulse = |pulse;

endmodule

// File: tb/tb_level_to_pulse_array.sv
// tb_level_to_pulse_array: directed table-driven checks of level_to_pulse_array
module tb_level_to_pulse_array;

`ifdef LTP_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [3:0] level;
      logic [7:0] mode;
      logic [3:0] exp;
      logic       exp_any;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] level, level_b;
   logic [7:0] mode, mode_b;
   logic [3:0] pulse, pulse_b;
   logic       any_pulse, any_b;

   int checks = 0;
   int failures = 0;

   vec_t tbl [26];

   level_to_pulse_array #(.N(4), .PULSE_LEN(3)) dut (
      .clk(clk), .reset(reset), .level(level), .mode(mode),
      .pulse(pulse), .any_pulse(any_pulse)
   );

   level_to_pulse_array #(.N(4), .PULSE_LEN(1)) dut_b (
      .clk(clk), .reset(reset), .level(level_b), .mode(mode_b),
      .pulse(pulse_b), .any_pulse(any_b)
   );

   always #20 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic [3:0] l, input logic [7:0] m, input logic [3:0] e, input logic a);
      return '{level: l, mode: m, exp: e, exp_any: a};
   endfunction

   initial begin
      // ch0 rise, ch1 fall, ch2 both, ch3 off
      tbl[0]  = v(4'b1110, 8'h00, 4'b0000, 1'b0);
      tbl[1]  = v(4'b1110, 8'h00, 4'b0000, 1'b0);
      tbl[2]  = v(4'b1110, 8'h00, 4'b0000, 1'b0);
      tbl[3]  = v(4'b1110, 8'h00, 4'b0000, 1'b0);
      tbl[4]  = v(4'b1111, 8'h39, 4'b0001, 1'b1);
      tbl[5]  = v(4'b1111, 8'h39, 4'b0001, 1'b1);
      tbl[6]  = v(4'b1111, 8'h39, 4'b0001, 1'b1);
      tbl[7]  = v(4'b1111, 8'h39, 4'b0000, 1'b0);
      tbl[8]  = v(4'b1111, 8'h39, 4'b0000, 1'b0);
      tbl[9]  = v(4'b1001, 8'h39, 4'b0110, 1'b1);
      tbl[10] = v(4'b1001, 8'h39, 4'b0110, 1'b1);
      tbl[11] = v(4'b1001, 8'h39, 4'b0110, 1'b1);
      tbl[12] = v(4'b1001, 8'h39, 4'b0000, 1'b0);
      tbl[13] = v(4'b1111, 8'h39, 4'b0100, 1'b1);
      tbl[14] = v(4'b1111, 8'h39, 4'b0100, 1'b1);
      tbl[15] = v(4'b1111, 8'h39, 4'b0100, 1'b1);
      tbl[16] = v(4'b1111, 8'h39, 4'b0000, 1'b0);
      tbl[17] = v(4'b1110, 8'h39, 4'b0000, 1'b0);
      tbl[18] = v(4'b1110, 8'h39, 4'b0000, 1'b0);
      tbl[19] = v(4'b1111, 8'h39, 4'b0001, 1'b1);
      tbl[20] = v(4'b1110, 8'h39, 4'b0001, 1'b1);
      tbl[21] = v(4'b1111, 8'h39, 4'b0001, 1'b1);
      tbl[22] = v(4'b1111, 8'h39, 4'b0001, 1'b1);
      tbl[23] = v(4'b1111, 8'h39, 4'b0001, 1'b1);
      tbl[24] = v(4'b1111, 8'h39, 4'b0000, 1'b0);
      tbl[25] = v(4'b1110, 8'h39, 4'b0000, 1'b0);

      reset   = 1'b0;
      level   = 4'b1000;
      mode    = 8'h40;
      level_b = 4'b0000;
      mode_b  = 8'hFF;
      #10;
      chk("reset pulse", {4'h0, pulse}, 8'h00);
      chk("reset any", {7'h0, any_pulse}, 8'h00);
      #11;
      chk("reset after edge pulse", {4'h0, pulse}, 8'h00);
      chk("reset pulse_b", {4'h0, pulse_b}, 8'h00);
      #9 reset = 1'b1;

      // level[3] held high across release
      for (int k = 1; k < LAT; k++) begin
         tick();
         chk($sformatf("release wait%0d", k), {4'h0, pulse}, 8'h00);
      end
      tick();
      chk("release pulse c1", {4'h0, pulse}, 8'h08);
      chk("release any c1", {7'h0, any_pulse}, 8'h01);
      tick();
      chk("release pulse c2", {4'h0, pulse}, 8'h08);
      #10 reset = 1'b0;
      #1;
      chk("async reset pulse", {4'h0, pulse}, 8'h00);
      chk("async reset any", {7'h0, any_pulse}, 8'h00);
      mode = 8'h00;
      #10 reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("no resume%0d", k), {4'h0, pulse}, 8'h00);
      end

      // table, outputs delayed by the input path latency
      for (int i = 0; i < 26; i++) begin
         int j;
         logic [3:0] e;
         logic ea;
         level = tbl[i].level;
         mode  = tbl[i].mode;
         tick();
         j  = i - (LAT - 1);
         e  = (j >= 0) ? tbl[j].exp : 4'b0000;
         ea = (j >= 0) ? tbl[j].exp_any : 1'b0;
         chk($sformatf("vec%0d pulse", i), {4'h0, pulse}, {4'h0, e});
         chk($sformatf("vec%0d any", i), {7'h0, any_pulse}, {7'h0, ea});
      end

      // mode off mid-pulse does not truncate
      level = 4'b1111;
      for (int k = 1; k < LAT; k++) begin
         tick();
         chk($sformatf("modeoff wait%0d", k), {4'h0, pulse}, 8'h00);
      end
      tick();
      chk("modeoff c1", {4'h0, pulse}, 8'h01);
      mode = 8'h38;
      tick();
      chk("modeoff c2", {4'h0, pulse}, 8'h01);
      tick();
      chk("modeoff c3", {4'h0, pulse}, 8'h01);
      tick();
      chk("modeoff end", {4'h0, pulse}, 8'h00);
      tick();
      chk("modeoff end any", {7'h0, any_pulse}, 8'h00);

      // PULSE_LEN=1, toggle every cycle, both edges
      for (int k = 1; k <= 8; k++) begin
         level_b = ~level_b;
         tick();
         if (k >= LAT) begin
            chk($sformatf("toggle%0d pulse_b", k), {4'h0, pulse_b}, 8'h0F);
            chk($sformatf("toggle%0d any_b", k), {7'h0, any_b}, 8'h01);
         end
      end
      mode_b = 8'h00;
      for (int k = 0; k < 4; k++) begin
         level_b = ~level_b;
         tick();
         chk($sformatf("toggle off%0d pulse_b", k), {4'h0, pulse_b}, 8'h00);
         chk($sformatf("toggle off%0d any_b", k), {7'h0, any_b}, 8'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
